// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and the load/store access-width codes used by the core decoder.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   typedef enum logic [2:0] {
      AW_B  = 3'b000,
      AW_H  = 3'b001,
      AW_W  = 3'b010,
      AW_BU = 3'b100,
      AW_HU = 3'b101
   } access_width_t;

   function automatic logic is_grant_state(arb_state_t s);
      return (s == ST_GNT_I) || (s == ST_GNT_D);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory bus seen by the arbiter.
// slave is the arbiter's view; master is the core + memory side.
interface mem_arbiter_if;

   logic        imem_req_i;
   logic [31:0] imem_addr_i;
   logic [31:0] imem_data_o;
   logic        imem_ack_o;

   logic        dmem_req_i;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_data_i;
   logic [2:0]  dmem_access_width_i;
   logic        dmem_we_i;
   logic [31:0] dmem_data_o;
   logic        dmem_ack_o;

   logic        mem_valid_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [2:0]  mem_access_width_o;
   logic        mem_ready_i;
   logic [31:0] mem_data_i;

   logic        hlt_o;
   logic        err_o;

   modport slave (
      input  imem_req_i, imem_addr_i,
      input  dmem_req_i, dmem_addr_i, dmem_data_i, dmem_access_width_i, dmem_we_i,
      input  mem_ready_i, mem_data_i,
      output imem_data_o, imem_ack_o, dmem_data_o, dmem_ack_o,
      output mem_valid_o, mem_we_o, mem_addr_o, mem_data_o, mem_access_width_o,
      output hlt_o, err_o
   );

   modport master (
      output imem_req_i, imem_addr_i,
      output dmem_req_i, dmem_addr_i, dmem_data_i, dmem_access_width_i, dmem_we_i,
      output mem_ready_i, mem_data_i,
      input  imem_data_o, imem_ack_o, dmem_data_o, dmem_ack_o,
      input  mem_valid_o, mem_we_o, mem_addr_o, mem_data_o, mem_access_width_o,
      input  hlt_o, err_o
   );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Loadable down-counter guarding a bus grant; expired flags the last
// permitted wait cycle so the arbiter can abort on the following edge.
module wait_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_value,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign expired = en && (count == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory bus between instruction fetch and
// data access; DMEM has priority with a starvation guard for IMEM.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate pending requests
// ST_GNT_I | fetch owns the bus; raise request, wait for ready or timeout
// ST_GNT_D | data access owns the bus; same handshake as ST_GNT_I
// ST_RESP  | one-cycle ack (and err on timeout) to the owner, then idle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   mem_arbiter_if.slave  bus
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT);

   arb_state_t    state;
   logic [SW-1:0] starve_cnt;

   logic          starved;
   logic          grant_d;
   logic          grant_i;
   logic          in_gnt;
   logic          timed_out;

   logic [31:0]   pend_addr;
   logic [31:0]   pend_data;
   logic [2:0]    pend_width;
   logic          pend_we;

   logic          mem_valid;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_wdata;
   logic [2:0]    mem_width;

   logic          imem_ack;
   logic          dmem_ack;
   logic [31:0]   imem_rdata;
   logic [31:0]   dmem_rdata;
   logic          err;

   // Starvation only matters while a fetch is actually waiting.
   always_comb begin
      starved = (starve_cnt == STARVE_MAX) && bus.imem_req_i;
      grant_d = (state == ST_IDLE) && bus.dmem_req_i && !starved;
      grant_i = (state == ST_IDLE) && bus.imem_req_i && !grant_d;
      in_gnt  = is_grant_state(state);
   end

   wait_timer #(
      .W (TW)
   ) u_wait_timer (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .load       (grant_d || grant_i),
      .en         (in_gnt),
      .load_value (TIMEOUT_LD),
      .expired    (timed_out)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         pend_addr  <= '0;
         pend_data  <= '0;
         pend_width <= AW_W;
         pend_we    <= 1'b0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_width  <= AW_W;
         imem_ack   <= 1'b0;
         dmem_ack   <= 1'b0;
         imem_rdata <= '0;
         dmem_rdata <= '0;
         err        <= 1'b0;
      end else begin
         imem_ack <= 1'b0;
         dmem_ack <= 1'b0;
         err      <= 1'b0;

         if (grant_i || !bus.imem_req_i) begin
            starve_cnt <= '0;
         end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end

         case (state)
            ST_IDLE: begin
               // Request fields are captured at grant so a requester that
               // drops out mid-transaction cannot corrupt the bus cycle.
               if (grant_d) begin
                  state      <= ST_GNT_D;
                  pend_addr  <= bus.dmem_addr_i;
                  pend_data  <= bus.dmem_data_i;
                  pend_width <= bus.dmem_access_width_i;
                  pend_we    <= bus.dmem_we_i;
               end else if (grant_i) begin
                  state      <= ST_GNT_I;
                  pend_addr  <= bus.imem_addr_i;
                  pend_data  <= '0;
                  pend_width <= AW_W;
                  pend_we    <= 1'b0;
               end
            end

            ST_GNT_I, ST_GNT_D: begin
               if (mem_valid && bus.mem_ready_i) begin
                  mem_valid <= 1'b0;
                  state     <= ST_RESP;
                  if (state == ST_GNT_I) begin
                     imem_ack   <= 1'b1;
                     imem_rdata <= bus.mem_data_i;
                  end else begin
                     dmem_ack   <= 1'b1;
                     dmem_rdata <= bus.mem_data_i;
                  end
               end else if (timed_out) begin
                  mem_valid <= 1'b0;
                  state     <= ST_RESP;
                  err       <= 1'b1;
                  if (state == ST_GNT_I) begin
                     imem_ack   <= 1'b1;
                     imem_rdata <= '0;
                  end else begin
                     dmem_ack   <= 1'b1;
                     dmem_rdata <= '0;
                  end
               end else if (!mem_valid) begin
                  mem_valid <= 1'b1;
                  mem_we    <= pend_we;
                  mem_addr  <= pend_addr;
                  mem_wdata <= pend_data;
                  mem_width <= pend_width;
               end
            end

            ST_RESP: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.imem_data_o        = imem_rdata;
   assign bus.imem_ack_o         = imem_ack;
   assign bus.dmem_data_o        = dmem_rdata;
   assign bus.dmem_ack_o         = dmem_ack;
   assign bus.mem_valid_o        = mem_valid;
   assign bus.mem_we_o           = mem_we;
   assign bus.mem_addr_o         = mem_addr;
   assign bus.mem_data_o         = mem_wdata;
   assign bus.mem_access_width_o = mem_width;
   assign bus.err_o              = err;
   assign bus.hlt_o              = (bus.imem_req_i & ~imem_ack) |
                                   (bus.dmem_req_i & ~dmem_ack);

endmodule
